// File: rtl/bnn_infer_sequencer.sv
// rtl/bnn_infer_sequencer.sv - weight-load, image-launch and result-handoff sequencer for the binarized CNN datapath
module bnn_infer_sequencer #(
  parameter int C1_OUT  = 18,
  parameter int C1_IN   = 5,
  parameter int C2_OUT  = 60,
  parameter int FC_OUT  = 10,
  parameter int FC_IN   = 960,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [24:0] cfg_data,
  output logic [1:0]  kernel_layer,
  output logic [1:0]  offset_layer,
  output logic [24:0] wr_kernel,
  output logic [8:0]  wr_number,
  output logic [4:0]  addr18,
  output logic [2:0]  addr5,
  output logic [3:0]  addr10,
  output logic [5:0]  addr60,
  output logic [9:0]  addr960,
  output logic        loaded,
  input  logic        img_valid,
  output logic        img_ready,
  output logic        eng_start,
  input  logic        eng_done,
  input  logic [3:0]  eng_class,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [3:0]  res_class,
  output logic        timeout_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LD_K1, ST_LD_B1, ST_LD_K2, ST_LD_B2,
    ST_LD_FCW, ST_LD_FCM, ST_READY, ST_RUN, ST_RESULT
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    outer_q, outer_d;
  logic [9:0]    inner_q, inner_d;
  logic [TW-1:0] run_cnt_q, run_cnt_d;
  logic          cfg_ready_q, cfg_ready_d;
  logic [1:0]    kernel_layer_q, kernel_layer_d;
  logic [1:0]    offset_layer_q, offset_layer_d;
  logic [24:0]   wr_kernel_q, wr_kernel_d;
  logic [8:0]    wr_number_q, wr_number_d;
  logic [4:0]    addr18_q, addr18_d;
  logic [2:0]    addr5_q, addr5_d;
  logic [3:0]    addr10_q, addr10_d;
  logic [5:0]    addr60_q, addr60_d;
  logic [9:0]    addr960_q, addr960_d;
  logic          loaded_q, loaded_d;
  logic          img_ready_q, img_ready_d;
  logic          eng_start_q, eng_start_d;
  logic          res_valid_q, res_valid_d;
  logic [3:0]    res_class_q, res_class_d;
  logic          timeout_err_q, timeout_err_d;

  logic          accept;
  logic          start_load;
  logic [5:0]    outer_last;
  logic [9:0]    inner_last;
  state_t        phase_next;

  // Loop bounds of the current load phase; single-index phases keep inner at 0.
  always_comb begin
    outer_last = '0;
    inner_last = '0;
    phase_next = ST_IDLE;
    case (state_q)
      ST_LD_K1:  begin outer_last = 6'(C1_OUT - 1); inner_last = 10'(C1_IN - 1);  phase_next = ST_LD_B1;  end
      ST_LD_B1:  begin outer_last = 6'(C1_OUT - 1);                               phase_next = ST_LD_K2;  end
      ST_LD_K2:  begin outer_last = 6'(C2_OUT - 1); inner_last = 10'(C1_OUT - 1); phase_next = ST_LD_B2;  end
      ST_LD_B2:  begin outer_last = 6'(C2_OUT - 1);                               phase_next = ST_LD_FCW; end
      ST_LD_FCW: begin outer_last = 6'(FC_OUT - 1); inner_last = 10'(FC_IN - 1);  phase_next = ST_LD_FCM; end
      ST_LD_FCM: begin outer_last = 6'(FC_OUT - 1);                               phase_next = ST_READY;  end
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    outer_d        = outer_q;
    inner_d        = inner_q;
    run_cnt_d      = run_cnt_q;
    kernel_layer_d = 2'd0;
    offset_layer_d = 2'd0;
    wr_kernel_d    = wr_kernel_q;
    wr_number_d    = wr_number_q;
    addr18_d       = addr18_q;
    addr5_d        = addr5_q;
    addr10_d       = addr10_q;
    addr60_d       = addr60_q;
    addr960_d      = addr960_q;
    loaded_d       = loaded_q;
    eng_start_d    = 1'b0;
    res_valid_d    = res_valid_q;
    res_class_d    = res_class_q;
    timeout_err_d  = timeout_err_q;

    accept     = cfg_valid && cfg_ready_q;
    start_load = cfg_start && (state_q == ST_IDLE || state_q == ST_READY);

    if (start_load) begin
      state_d       = ST_LD_K1;
      outer_d       = '0;
      inner_d       = '0;
      run_cnt_d     = '0;
      loaded_d      = 1'b0;
      timeout_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_READY: begin
          if (img_valid) begin
            eng_start_d = 1'b1;
            run_cnt_d   = '0;
            state_d     = ST_RUN;
          end
        end
        ST_RUN: begin
          if (eng_done) begin
            res_class_d = eng_class;
            res_valid_d = 1'b1;
            state_d     = ST_RESULT;
          end else if (run_cnt_q == TW'(TIMEOUT - 1)) begin
            timeout_err_d = 1'b1;
            state_d       = ST_READY;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            state_d     = ST_READY;
          end
        end
        default: begin
          if (accept) begin
            case (state_q)
              ST_LD_K1: begin
                kernel_layer_d = 2'd1;
                addr18_d       = outer_q[4:0];
                addr5_d        = inner_q[2:0];
                wr_kernel_d    = cfg_data;
              end
              ST_LD_B1: begin
                offset_layer_d = 2'd1;
                addr18_d       = outer_q[4:0];
                wr_number_d    = {2'b00, cfg_data[6:0]};
              end
              ST_LD_K2: begin
                kernel_layer_d = 2'd2;
                addr60_d       = outer_q;
                addr18_d       = inner_q[4:0];
                wr_kernel_d    = cfg_data;
              end
              ST_LD_B2: begin
                offset_layer_d = 2'd2;
                addr60_d       = outer_q;
                wr_number_d    = cfg_data[8:0];
              end
              ST_LD_FCW: begin
                kernel_layer_d = 2'd3;
                addr10_d       = outer_q[3:0];
                addr960_d      = inner_q;
                wr_number_d    = {8'd0, cfg_data[0]};
              end
              ST_LD_FCM: begin
                offset_layer_d = 2'd3;
                addr10_d       = outer_q[3:0];
                wr_number_d    = {1'b0, cfg_data[7:0]};
              end
              default: ;
            endcase

            // Inner index runs fastest; the phase ends on its final word.
            if (inner_q == inner_last) begin
              inner_d = '0;
              if (outer_q == outer_last) begin
                outer_d = '0;
                state_d = phase_next;
                if (phase_next == ST_READY) loaded_d = 1'b1;
              end else begin
                outer_d = outer_q + 6'd1;
              end
            end else begin
              inner_d = inner_q + 10'd1;
            end
          end
        end
      endcase
    end

    cfg_ready_d = (state_d == ST_LD_K1) || (state_d == ST_LD_B1) || (state_d == ST_LD_K2) ||
                  (state_d == ST_LD_B2) || (state_d == ST_LD_FCW) || (state_d == ST_LD_FCM);
    img_ready_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      outer_q        <= '0;
      inner_q        <= '0;
      run_cnt_q      <= '0;
      cfg_ready_q    <= 1'b0;
      kernel_layer_q <= 2'd0;
      offset_layer_q <= 2'd0;
      wr_kernel_q    <= '0;
      wr_number_q    <= '0;
      addr18_q       <= '0;
      addr5_q        <= '0;
      addr10_q       <= '0;
      addr60_q       <= '0;
      addr960_q      <= '0;
      loaded_q       <= 1'b0;
      img_ready_q    <= 1'b0;
      eng_start_q    <= 1'b0;
      res_valid_q    <= 1'b0;
      res_class_q    <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      outer_q        <= outer_d;
      inner_q        <= inner_d;
      run_cnt_q      <= run_cnt_d;
      cfg_ready_q    <= cfg_ready_d;
      kernel_layer_q <= kernel_layer_d;
      offset_layer_q <= offset_layer_d;
      wr_kernel_q    <= wr_kernel_d;
      wr_number_q    <= wr_number_d;
      addr18_q       <= addr18_d;
      addr5_q        <= addr5_d;
      addr10_q       <= addr10_d;
      addr60_q       <= addr60_d;
      addr960_q      <= addr960_d;
      loaded_q       <= loaded_d;
      img_ready_q    <= img_ready_d;
      eng_start_q    <= eng_start_d;
      res_valid_q    <= res_valid_d;
      res_class_q    <= res_class_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign kernel_layer = kernel_layer_q;
  assign offset_layer = offset_layer_q;
  assign wr_kernel    = wr_kernel_q;
  assign wr_number    = wr_number_q;
  assign addr18       = addr18_q;
  assign addr5        = addr5_q;
  assign addr10       = addr10_q;
  assign addr60       = addr60_q;
  assign addr960      = addr960_q;
  assign loaded       = loaded_q;
  assign img_ready    = img_ready_q;
  assign eng_start    = eng_start_q;
  assign res_valid    = res_valid_q;
  assign res_class    = res_class_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_bnn_infer_sequencer.sv
// tb/tb_bnn_infer_sequencer.sv - directed bench for bnn_infer_sequencer
module tb_bnn_infer_sequencer;

  localparam int TOTAL = 10858;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0, cfg_valid = 1'b0, img_valid = 1'b0, eng_done = 1'b0, res_ready = 1'b0;
  logic [24:0] cfg_data = '0;
  logic [3:0]  eng_class = '0;

  logic        cfg_ready, loaded, img_ready, eng_start, res_valid, timeout_err;
  logic [1:0]  kernel_layer, offset_layer;
  logic [24:0] wr_kernel;
  logic [8:0]  wr_number;
  logic [4:0]  addr18;
  logic [2:0]  addr5;
  logic [3:0]  addr10, res_class;
  logic [5:0]  addr60;
  logic [9:0]  addr960;

  logic        t_cfg_ready, t_loaded, t_img_ready, t_eng_start, t_res_valid, t_timeout_err;
  logic [1:0]  t_kernel_layer, t_offset_layer;
  logic [24:0] t_wr_kernel;
  logic [8:0]  t_wr_number;
  logic [4:0]  t_addr18;
  logic [2:0]  t_addr5;
  logic [3:0]  t_addr10, t_res_class;
  logic [5:0]  t_addr60;
  logic [9:0]  t_addr960;

  always #5 clk = ~clk;

  bnn_infer_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .kernel_layer(kernel_layer), .offset_layer(offset_layer),
    .wr_kernel(wr_kernel), .wr_number(wr_number), .addr18(addr18), .addr5(addr5),
    .addr10(addr10), .addr60(addr60), .addr960(addr960), .loaded(loaded),
    .img_valid(img_valid), .img_ready(img_ready), .eng_start(eng_start), .eng_done(eng_done),
    .eng_class(eng_class), .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .timeout_err(timeout_err)
  );

  bnn_infer_sequencer #(.TIMEOUT(64)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(t_cfg_ready),
    .cfg_data(cfg_data), .kernel_layer(t_kernel_layer), .offset_layer(t_offset_layer),
    .wr_kernel(t_wr_kernel), .wr_number(t_wr_number), .addr18(t_addr18), .addr5(t_addr5),
    .addr10(t_addr10), .addr60(t_addr60), .addr960(t_addr960), .loaded(t_loaded),
    .img_valid(img_valid), .img_ready(t_img_ready), .eng_start(t_eng_start), .eng_done(eng_done),
    .eng_class(eng_class), .res_valid(t_res_valid), .res_ready(res_ready), .res_class(t_res_class),
    .timeout_err(t_timeout_err)
  );

  wire [75:0] dut_outs = {cfg_ready, kernel_layer, offset_layer, wr_kernel, wr_number, addr18, addr5,
                          addr10, addr60, addr960, loaded, img_ready, eng_start, res_valid, res_class,
                          timeout_err};
  wire [75:0] t_outs = {t_cfg_ready, t_kernel_layer, t_offset_layer, t_wr_kernel, t_wr_number, t_addr18,
                        t_addr5, t_addr10, t_addr60, t_addr960, t_loaded, t_img_ready, t_eng_start,
                        t_res_valid, t_res_class, t_timeout_err};

  int n_cmp = 0;
  int n_err = 0;
  int n_strb = 0;

  logic [1:0]  e_kl = '0, e_ol = '0;
  logic [4:0]  e_a18 = '0;
  logic [2:0]  e_a5 = '0;
  logic [5:0]  e_a60 = '0;
  logic [3:0]  e_a10 = '0;
  logic [9:0]  e_a960 = '0;
  logic [24:0] e_wk = '0;
  logic [8:0]  e_wn = '0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] dat(input int k);
    logic [31:0] h;
    h = 32'(k) * 32'h9E3779B1;
    return h[31:7];
  endfunction

  // Reference model of the write stream: fields not written by a phase keep their last value.
  always @(negedge clk) begin : mon
    int n, j;
    logic [24:0] d;
    if (rst_n && (kernel_layer != 2'd0 || offset_layer != 2'd0)) begin
      n = n_strb;
      d = dat(n);
      e_kl = 2'd0;
      e_ol = 2'd0;
      if (n < 90) begin
        e_kl = 2'd1; e_a18 = 5'(n / 5); e_a5 = 3'(n % 5); e_wk = d;
      end else if (n < 108) begin
        e_ol = 2'd1; e_a18 = 5'(n - 90); e_wn = {2'b00, d[6:0]};
      end else if (n < 1188) begin
        j = n - 108; e_kl = 2'd2; e_a60 = 6'(j / 18); e_a18 = 5'(j % 18); e_wk = d;
      end else if (n < 1248) begin
        e_ol = 2'd2; e_a60 = 6'(n - 1188); e_wn = d[8:0];
      end else if (n < 10848) begin
        j = n - 1248; e_kl = 2'd3; e_a10 = 4'(j / 960); e_a960 = 10'(j % 960); e_wn = {8'd0, d[0]};
      end else begin
        e_ol = 2'd3; e_a10 = 4'(n - 10848); e_wn = {1'b0, d[7:0]};
      end
      check($sformatf("strobe%0d", n),
            {loaded, kernel_layer, offset_layer, addr18, addr5, addr60, addr10, addr960, wr_kernel, wr_number},
            {(n == TOTAL - 1), e_kl, e_ol, e_a18, e_a5, e_a60, e_a10, e_a960, e_wk, e_wn});
      n_strb++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic do_load(input int stop_at, input bit toggle, input int gap_at, input int img_at);
    int k, cyc, gap;
    bit v, rdy, iv;
    k = 0; cyc = 0; gap = 0;
    while (k < stop_at && cyc < 60000) begin
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      if (k == gap_at && gap < 50) begin
        v = 1'b0;
        gap++;
      end
      iv = (k == img_at);
      cfg_valid = v;
      cfg_data  = dat(k);
      img_valid = iv;
      rdy = cfg_ready;
      @(posedge clk); #1;
      if (iv) begin
        check("img_ignored_start", eng_start, 0);
        check("img_ignored_ready", img_ready, 0);
      end
      if (v && rdy) k++;
      cyc++;
    end
    cfg_valid = 1'b0;
    img_valid = 1'b0;
    check("load_words", k, stop_at);
  endtask

  initial begin
    #22;
    check("reset_outs", dut_outs, 0);
    check("reset_outs_to", t_outs, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(2);
    check("idle_cfg_ready", cfg_ready, 0);

    pulse_start();
    check("cfg_ready_after_start", cfg_ready, 1);
    n_strb = 0;
    do_load(TOTAL, 1'b0, -1, -1);
    cycles(2);
    check("strobes_full", n_strb, TOTAL);
    check("loaded_full", loaded, 1);
    check("cfg_ready_in_ready", cfg_ready, 0);
    check("img_ready_loaded", img_ready, 1);

    img_valid = 1'b1;
    @(posedge clk); #1;
    img_valid = 1'b0;
    check("eng_start_pulse", eng_start, 1);
    check("img_ready_run", img_ready, 0);
    @(posedge clk); #1;
    check("eng_start_single", eng_start, 0);
    for (int i = 2; i <= 300; i++) begin
      @(posedge clk); #1;
      if (i == 63) check("to_before", t_timeout_err, 0);
      if (i == 64) begin
        check("to_flag", t_timeout_err, 1);
        check("to_img_ready", t_img_ready, 1);
        check("to_no_result", t_res_valid, 0);
      end
    end
    check("no_early_result", res_valid, 0);
    check("no_timeout_long", timeout_err, 0);
    eng_done = 1'b1;
    eng_class = 4'd7;
    @(posedge clk); #1;
    eng_done = 1'b0;
    eng_class = 4'd0;
    check("res_valid", res_valid, 1);
    check("res_class", res_class, 7);
    check("to_done_ignored", t_res_valid, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("res_hold_valid", res_valid, 1);
      check("res_hold_class", res_class, 7);
      check("res_hold_no_img", img_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("res_consumed", res_valid, 0);
    check("img_ready_after_res", img_ready, 1);

    img_valid = 1'b1;
    @(posedge clk); #1;
    img_valid = 1'b0;
    check("eng_start_2", eng_start, 1);
    cycles(3);
    pulse_start();
    check("run_start_ign_ready", cfg_ready, 0);
    check("run_start_ign_kl", kernel_layer, 0);
    check("run_start_ign_img", img_ready, 0);
    check("run_start_ign_loaded", loaded, 1);
    check("run_start_ign_to", t_timeout_err, 1);
    cycles(3);
    eng_done = 1'b1;
    eng_class = 4'd3;
    @(posedge clk); #1;
    eng_done = 1'b0;
    check("res_class_2", res_class, 3);
    check("res_class_2_to", t_res_class, 3);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("img_ready_2", img_ready, 1);

    pulse_start();
    check("loaded_cleared", loaded, 0);
    check("to_cleared", t_timeout_err, 0);
    n_strb = 0;
    do_load(TOTAL, 1'b1, 5000, 1200);
    cycles(2);
    check("strobes_toggle", n_strb, TOTAL);
    check("loaded_toggle", loaded, 1);

    pulse_start();
    n_strb = 0;
    do_load(608, 1'b0, -1, -1);
    @(negedge clk); #1;
    check("strobes_before_reset", n_strb, 608);
    rst_n = 1'b0;
    #1;
    check("midload_reset_outs", dut_outs, 0);
    check("midload_reset_outs_to", t_outs, 0);
    e_kl = '0; e_ol = '0; e_a18 = '0; e_a5 = '0; e_a60 = '0; e_a10 = '0; e_a960 = '0; e_wk = '0; e_wn = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(1);
    pulse_start();
    n_strb = 0;
    do_load(1, 1'b0, -1, -1);
    cycles(1);
    check("restart_strobes", n_strb, 1);
    check("restart_loaded", loaded, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
